// File: rtl/ifetch_miss_queue.sv
// ifetch_miss_queue
//
// Tracks outstanding L1 instruction cache misses. Misses from different threads
// to the same cache line share one entry, so only one L2 fill goes out per line.
// Queued entries are offered round-robin on a registered valid/ready L2 request
// port. A fill response wakes every thread recorded in that entry's mask.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   miss_en/_paddr/_thread_idx   miss report from the ifetch data stage
//   l2_req_valid/_paddr/_id/_ready   fill request handshake (registered outputs)
//   l2_resp_valid/_id   fill completion for entry l2_resp_id
//   wake_en/wake_bitmap single-cycle wake of the threads waiting on a line
//   miss_merged         pulse: a miss joined an existing entry
//   pending_count       number of entries not IDLE
//
// The round-robin wrap relies on NUM_THREADS being a power of two.
module ifetch_miss_queue #(
   parameter int NUM_THREADS = 4,
   parameter int ADDR_WIDTH  = 26,
   parameter int ID_WIDTH    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  miss_en,
   input  logic [ADDR_WIDTH-1:0] miss_paddr,
   input  logic [ID_WIDTH-1:0]   miss_thread_idx,
   output logic                  l2_req_valid,
   output logic [ADDR_WIDTH-1:0] l2_req_paddr,
   output logic [ID_WIDTH-1:0]   l2_req_id,
   input  logic                  l2_req_ready,
   input  logic                  l2_resp_valid,
   input  logic [ID_WIDTH-1:0]   l2_resp_id,
   output logic                  wake_en,
   output logic [NUM_THREADS-1:0] wake_bitmap,
   output logic                  miss_merged,
   output logic [ID_WIDTH:0]     pending_count
);

   typedef enum logic [1:0] {IDLE, QUEUED, PRESENTED, WAIT_RESP} entry_state_e;

   entry_state_e            state_q [NUM_THREADS];
   entry_state_e            state_d [NUM_THREADS];
   logic [ADDR_WIDTH-1:0]   paddr_q [NUM_THREADS];
   logic [ADDR_WIDTH-1:0]   paddr_d [NUM_THREADS];
   logic [NUM_THREADS-1:0]  mask_q  [NUM_THREADS];
   logic [NUM_THREADS-1:0]  mask_d  [NUM_THREADS];

   logic [ID_WIDTH-1:0]     rr_q, rr_d;
   logic                    req_valid_q, req_valid_d;
   logic [ADDR_WIDTH-1:0]   req_paddr_q, req_paddr_d;
   logic [ID_WIDTH-1:0]     req_id_q, req_id_d;
   logic                    wake_en_q, wake_en_d;
   logic [NUM_THREADS-1:0]  wake_bitmap_q, wake_bitmap_d;
   logic                    merged_q, merged_d;
   logic                    after_reset_q;

   logic                    handshake, resp_hit, dup, match_hit, alloc_found, sel_found;
   logic [ID_WIDTH-1:0]     match_idx, alloc_idx, sel_idx, rr_eff, cand;
   logic [NUM_THREADS-1:0]  thread_bit;

   // Entry bookkeeping. Handshake, response, selection and allocation always touch
   // entries in different states, so they can all be applied in one cycle. The
   // response is applied after the merge so a miss landing on a completing line
   // is folded into that line's wake bitmap (near-miss window).
   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         state_d[i] = state_q[i];
         paddr_d[i] = paddr_q[i];
         mask_d[i]  = mask_q[i];
      end
      rr_d          = rr_q;
      req_valid_d   = req_valid_q;
      req_paddr_d   = req_paddr_q;
      req_id_d      = req_id_q;
      wake_en_d     = 1'b0;
      wake_bitmap_d = '0;
      merged_d      = 1'b0;
      thread_bit    = '0;
      thread_bit[miss_thread_idx] = 1'b1;
      dup           = 1'b0;
      match_hit     = 1'b0;
      match_idx     = '0;
      alloc_found   = 1'b0;
      alloc_idx     = '0;
      sel_found     = 1'b0;
      sel_idx       = '0;
      cand          = '0;

      handshake = req_valid_q && l2_req_ready;
      resp_hit  = l2_resp_valid && (state_q[l2_resp_id] == WAIT_RESP);
      rr_eff    = handshake ? req_id_q + ID_WIDTH'(1) : rr_q;

      if (handshake) begin
         state_d[req_id_q] = WAIT_RESP;
         rr_d              = req_id_q + ID_WIDTH'(1);
      end

      for (int i = 0; i < NUM_THREADS; i++) begin
         if ((mask_q[i] & thread_bit) != '0) dup = 1'b1;
         if (!match_hit && state_q[i] != IDLE && paddr_q[i] == miss_paddr) begin
            match_hit = 1'b1;
            match_idx = ID_WIDTH'(i);
         end
         if (!alloc_found && state_q[i] == IDLE) begin
            alloc_found = 1'b1;
            alloc_idx   = ID_WIDTH'(i);
         end
      end

      // A thread already waiting on a line cannot miss again; such a miss is dropped.
      if (miss_en && !dup) begin
         if (match_hit) begin
            mask_d[match_idx] = mask_q[match_idx] | thread_bit;
            merged_d          = 1'b1;
         end else if (alloc_found) begin
            state_d[alloc_idx] = QUEUED;
            paddr_d[alloc_idx] = miss_paddr;
            mask_d[alloc_idx]  = thread_bit;
         end
      end

      if (resp_hit) begin
         wake_en_d           = 1'b1;
         wake_bitmap_d       = mask_d[l2_resp_id];
         state_d[l2_resp_id] = IDLE;
         mask_d[l2_resp_id]  = '0;
      end

      // The request register reloads only when empty or just accepted, which keeps
      // valid/paddr/id stable under backpressure.
      if (!req_valid_q || handshake) begin
         for (int k = 0; k < NUM_THREADS; k++) begin
            cand = rr_eff + ID_WIDTH'(k);
            if (!sel_found && state_q[cand] == QUEUED) begin
               sel_found = 1'b1;
               sel_idx   = cand;
            end
         end
         if (sel_found) begin
            state_d[sel_idx] = PRESENTED;
            req_valid_d      = 1'b1;
            req_paddr_d      = paddr_q[sel_idx];
            req_id_d         = sel_idx;
         end else begin
            req_valid_d = 1'b0;
            req_paddr_d = '0;
            req_id_d    = '0;
         end
      end
   end

   // State registers. after_reset_q masks the response check for the first cycle
   // out of reset, when the L2 may still return a pre-reset id.
   always_ff @(posedge clk) begin
      after_reset_q <= reset;
      if (reset) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            state_q[i] <= IDLE;
            paddr_q[i] <= '0;
            mask_q[i]  <= '0;
         end
         rr_q          <= '0;
         req_valid_q   <= 1'b0;
         req_paddr_q   <= '0;
         req_id_q      <= '0;
         wake_en_q     <= 1'b0;
         wake_bitmap_q <= '0;
         merged_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            state_q[i] <= state_d[i];
            paddr_q[i] <= paddr_d[i];
            mask_q[i]  <= mask_d[i];
         end
         rr_q          <= rr_d;
         req_valid_q   <= req_valid_d;
         req_paddr_q   <= req_paddr_d;
         req_id_q      <= req_id_d;
         wake_en_q     <= wake_en_d;
         wake_bitmap_q <= wake_bitmap_d;
         merged_q      <= merged_d;
         if (miss_en) assert (!dup);
         if (l2_resp_valid && !after_reset_q) assert (state_q[l2_resp_id] == WAIT_RESP);
      end
   end

   // Occupancy count over the registered entry states.
   always_comb begin
      pending_count = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (state_q[i] != IDLE) pending_count = pending_count + (ID_WIDTH+1)'(1);
      end
   end

   assign l2_req_valid = req_valid_q;
   assign l2_req_paddr = req_paddr_q;
   assign l2_req_id    = req_id_q;
   assign wake_en      = wake_en_q;
   assign wake_bitmap  = wake_bitmap_q;
   assign miss_merged  = merged_q;

endmodule

// File: tb/tb_ifetch_miss_queue.sv
// tb_ifetch_miss_queue
//
// Directed bench for ifetch_miss_queue. Expected L2 requests and wake bitmaps are
// queued as stimulus is driven; a negedge monitor pops and compares them when the
// DUT handshakes a request or pulses wake_en.
module tb_ifetch_miss_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        miss_en;
   logic [25:0] miss_paddr;
   logic [1:0]  miss_thread_idx;
   logic        l2_req_valid;
   logic [25:0] l2_req_paddr;
   logic [1:0]  l2_req_id;
   logic        l2_req_ready;
   logic        l2_resp_valid;
   logic [1:0]  l2_resp_id;
   logic        wake_en;
   logic [3:0]  wake_bitmap;
   logic        miss_merged;
   logic [2:0]  pending_count;

   typedef struct {
      logic [25:0] paddr;
      logic [1:0]  id;
   } req_t;

   req_t       exp_req [$];
   logic [3:0] exp_wake [$];
   req_t       mon_r;
   logic [3:0] mon_w;
   int         compared   = 0;
   int         mismatched = 0;
   int         merged_seen = 0;
   logic       mon_on = 1'b0;

   ifetch_miss_queue #(.NUM_THREADS(4), .ADDR_WIDTH(26), .ID_WIDTH(2)) dut (
      .clk(clk), .reset(reset),
      .miss_en(miss_en), .miss_paddr(miss_paddr), .miss_thread_idx(miss_thread_idx),
      .l2_req_valid(l2_req_valid), .l2_req_paddr(l2_req_paddr), .l2_req_id(l2_req_id),
      .l2_req_ready(l2_req_ready),
      .l2_resp_valid(l2_resp_valid), .l2_resp_id(l2_resp_id),
      .wake_en(wake_en), .wake_bitmap(wake_bitmap),
      .miss_merged(miss_merged), .pending_count(pending_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_req(input logic [25:0] pa, input logic [1:0] id);
      req_t r;
      r.paddr = pa;
      r.id    = id;
      exp_req.push_back(r);
   endtask

   task automatic miss(input logic [1:0] t, input logic [25:0] pa);
      miss_en         = 1'b1;
      miss_thread_idx = t;
      miss_paddr      = pa;
      tick();
      miss_en = 1'b0;
   endtask

   task automatic resp(input logic [1:0] id, input logic [3:0] bm);
      exp_wake.push_back(bm);
      l2_resp_valid = 1'b1;
      l2_resp_id    = id;
      tick();
      l2_resp_valid = 1'b0;
   endtask

   task automatic check_hold();
      check("t4_hold_valid", l2_req_valid, 1);
      check("t4_hold_paddr", l2_req_paddr, 26'h400);
      check("t4_hold_id",    l2_req_id,    0);
   endtask

   // Scoreboard monitor: values seen at negedge are what the next posedge samples.
   always @(negedge clk) begin
      if (mon_on) begin
         if (l2_req_valid && l2_req_ready) begin
            check("req_expected", exp_req.size() != 0, 1);
            if (exp_req.size() != 0) begin
               mon_r = exp_req.pop_front();
               check("req_paddr", l2_req_paddr, mon_r.paddr);
               check("req_id",    l2_req_id,    mon_r.id);
            end
         end
         if (wake_en) begin
            check("wake_expected", exp_wake.size() != 0, 1);
            if (exp_wake.size() != 0) begin
               mon_w = exp_wake.pop_front();
               check("wake_bitmap", wake_bitmap, mon_w);
            end
         end else begin
            check("wake_bitmap_idle", wake_bitmap, 0);
         end
         if (miss_merged) merged_seen++;
      end
   end

   initial begin
      reset = 1'b1; miss_en = 1'b0; miss_paddr = '0; miss_thread_idx = '0;
      l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_id = '0;
      idle(2);
      reset = 1'b0;
      check("rst_valid",   l2_req_valid, 0);
      check("rst_paddr",   l2_req_paddr, 0);
      check("rst_id",      l2_req_id,    0);
      check("rst_wake",    wake_en,      0);
      check("rst_bitmap",  wake_bitmap,  0);
      check("rst_merged",  miss_merged,  0);
      check("rst_pending", pending_count, 0);
      mon_on = 1'b1;

      // Test 1: single miss, request at cycle 2, response at 5, wake at 6
      push_req(26'h100, 0);
      miss(1, 26'h100);
      check("t1_pending_c1", pending_count, 1);
      check("t1_valid_c1",   l2_req_valid,  0);
      tick();
      check("t1_valid_c2",   l2_req_valid,  1);
      check("t1_paddr_c2",   l2_req_paddr,  26'h100);
      check("t1_id_c2",      l2_req_id,     0);
      l2_req_ready = 1'b1;
      tick();
      check("t1_valid_after_grant", l2_req_valid, 0);
      check("t1_pending_wait", pending_count, 1);
      idle(2);
      resp(0, 4'b0010);
      check("t1_wake_en",     wake_en,       1);
      check("t1_wake_bitmap", wake_bitmap,   4'b0010);
      check("t1_pending_end", pending_count, 0);

      // Test 2: merge on a presented entry in the cycle it is accepted
      push_req(26'h200, 0);
      miss(0, 26'h200);
      tick();
      miss(3, 26'h200);
      check("t2_merged_pulse", miss_merged, 1);
      idle(3);
      resp(0, 4'b1001);
      check("t2_merge_count", merged_seen, 1);
      check("t2_pending_end", pending_count, 0);

      // Test 3: near-miss, miss and response to the same line in one cycle
      push_req(26'h300, 0);
      miss(0, 26'h300);
      idle(4);
      exp_wake.push_back(4'b0101);
      miss_en = 1'b1; miss_thread_idx = 2; miss_paddr = 26'h300;
      l2_resp_valid = 1'b1; l2_resp_id = 0;
      tick();
      miss_en = 1'b0; l2_resp_valid = 1'b0;
      check("t3_wake_bitmap", wake_bitmap, 4'b0101);
      idle(4);
      check("t3_merge_count", merged_seen, 2);
      check("t3_pending_end", pending_count, 0);

      // Test 4: backpressure and in-order round-robin grants
      l2_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_req(26'h400 + 26'(i), 2'(i));
      miss(0, 26'h400);
      miss(1, 26'h401);
      check_hold();
      miss(2, 26'h402);
      check_hold();
      miss(3, 26'h403);
      check_hold();
      for (int i = 0; i < 2; i++) begin
         tick();
         check_hold();
      end
      check("t4_pending_full", pending_count, 4);
      l2_req_ready = 1'b1;
      idle(6);
      check("t4_reqs_drained", exp_req.size(), 0);
      for (int i = 0; i < 4; i++) resp(2'(i), 4'(1 << i));
      idle(2);
      check("t4_pending_end", pending_count, 0);

      // Test 5: pointer at 3 with entries 0 and 3 queued grants 3 then 0
      push_req(26'h500, 0);
      miss(0, 26'h500);
      idle(3);
      push_req(26'h501, 1);
      miss(1, 26'h501);
      idle(3);
      l2_req_ready = 1'b0;
      push_req(26'h502, 2);
      push_req(26'h503, 3);
      push_req(26'h504, 0);
      miss(2, 26'h502);
      tick();
      check("t5_presented_id", l2_req_id, 2);
      resp(0, 4'b0001);
      miss(0, 26'h504);
      miss(3, 26'h503);
      check("t5_pending_full", pending_count, 4);
      l2_req_ready = 1'b1;
      idle(4);
      check("t5_reqs_drained", exp_req.size(), 0);
      resp(1, 4'b0010);
      resp(2, 4'b0100);
      resp(3, 4'b1000);
      resp(0, 4'b0001);
      idle(2);
      check("t5_pending_end", pending_count, 0);

      // Test 6: reset with two entries in WAIT_RESP, then a stale response
      push_req(26'h600, 0);
      miss(0, 26'h600);
      push_req(26'h601, 1);
      miss(1, 26'h601);
      idle(4);
      check("t6_pending_pre", pending_count, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_valid",   l2_req_valid, 0);
      check("t6_rst_wake",    wake_en,      0);
      check("t6_rst_merged",  miss_merged,  0);
      check("t6_rst_pending", pending_count, 0);
      l2_resp_valid = 1'b1;
      l2_resp_id    = 1;
      tick();
      l2_resp_valid = 1'b0;
      check("t6_stale_wake", wake_en, 0);
      tick();
      check("t6_stale_wake_late", wake_en, 0);
      check("t6_pending_end", pending_count, 0);

      check("end_req_queue",  exp_req.size(),  0);
      check("end_wake_queue", exp_wake.size(), 0);
      mon_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
